// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared verdict/state encoding for the bit-serial comparators
package serial_cmp_pkg;
  typedef enum logic [1:0] {EQ, LESS, GREATER} cmp_state_t;
endpackage

// File: rtl/serial_comparator_least_significant_first_using_fsm.sv
// serial_comparator_least_significant_first_using_fsm: LSB-first serial compare, later differing bit wins
module serial_comparator_least_significant_first_using_fsm
  import serial_cmp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic a_less_b,
  output logic a_eq_b,
  output logic a_greater_b
);
  cmp_state_t state, verdict;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= EQ;
    else state <= verdict;
  always_comb begin
    verdict = (a & ~b) ? GREATER : (~a & b) ? LESS : state;
    a_less_b = verdict == LESS;
    a_eq_b = verdict == EQ;
    a_greater_b = verdict == GREATER;
  end
endmodule

// File: rtl/serial_comparator_most_significant_first_using_fsm.sv
// serial_comparator_most_significant_first_using_fsm: MSB-first serial compare, first differing bit locks
module serial_comparator_most_significant_first_using_fsm
  import serial_cmp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic a_less_b,
  output logic a_eq_b,
  output logic a_greater_b
);
  cmp_state_t state, verdict;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= EQ;
    else state <= verdict;
  always_comb begin
    verdict = (state != EQ) ? state : (a & ~b) ? GREATER : (~a & b) ? LESS : EQ;
    a_less_b = verdict == LESS;
    a_eq_b = verdict == EQ;
    a_greater_b = verdict == GREATER;
  end
endmodule

// File: rtl/serial_comparator_pair_fsm.sv
// serial_comparator_pair_fsm: LSB-first and MSB-first serial comparators on the same bit stream
module serial_comparator_pair_fsm (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic lsf_less,
  output logic lsf_eq,
  output logic lsf_greater,
  output logic msf_less,
  output logic msf_eq,
  output logic msf_greater
);
  serial_comparator_least_significant_first_using_fsm u_lsf (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .a_less_b(lsf_less), .a_eq_b(lsf_eq), .a_greater_b(lsf_greater)
  );
  serial_comparator_most_significant_first_using_fsm u_msf (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .a_less_b(msf_less), .a_eq_b(msf_eq), .a_greater_b(msf_greater)
  );
endmodule

// File: tb/tb_serial_comparator_pair_fsm.sv
// tb_serial_comparator_pair_fsm: scoreboard bench for the LSB-/MSB-first serial comparator pair
module tb_serial_comparator_pair_fsm;
  logic clk = 0, rst, a, b;
  logic lsf_less, lsf_eq, lsf_greater, msf_less, msf_eq, msf_greater;
  logic [5:0] obs;
  logic [5:0] sb_q[$];
  int n_checks = 0, n_errors = 0;

  serial_comparator_pair_fsm dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .lsf_less(lsf_less), .lsf_eq(lsf_eq), .lsf_greater(lsf_greater),
    .msf_less(msf_less), .msf_eq(msf_eq), .msf_greater(msf_greater)
  );

  always #5 clk = ~clk;
  assign obs = {lsf_less, lsf_eq, lsf_greater, msf_less, msf_eq, msf_greater};

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 0; a = 0; b = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic push_table(input int n, input logic [15:0] el, ee, eg, ml, me, mg);
    for (int j = 0; j < n; j++) sb_q.push_back({el[j], ee[j], eg[j], ml[j], me[j], mg[j]});
  endtask

  // Reference: LSB-first compares the low j+1 bits; MSB-first shifts bits in so bit 0 is most significant.
  task automatic push_model(input logic [63:0] va, vb, input int n);
    logic [63:0] mask, la, lb, pa, pb;
    pa = 0; pb = 0;
    for (int j = 0; j < n; j++) begin
      mask = (j == 63) ? '1 : ((64'd1 << (j + 1)) - 64'd1);
      la = va & mask; lb = vb & mask;
      pa = {pa[62:0], va[j]}; pb = {pb[62:0], vb[j]};
      sb_q.push_back({la < lb, la == lb, la > lb, pa < pb, pa == pb, pa > pb});
    end
  endtask

  task automatic drive(input string tag, input logic [63:0] va, vb, input int n);
    logic [5:0] exp;
    for (int j = 0; j < n; j++) begin
      a = va[j]; b = vb[j];
      @(negedge clk);
      exp = sb_q.pop_front();
      check($sformatf("%s_bit%0d", tag, j), obs, exp);
      check($sformatf("%s_onehot%0d", tag, j), {4'b0, $onehot(obs[5:3]), $onehot(obs[2:0])}, 6'b000011);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [63:0] va, vb;
    int n;
    rst = 0; a = 1; b = 0;
    #2;
    check("rst_a_gt_b", obs, 6'b001001);
    a = 0; b = 1; #1;
    check("rst_a_lt_b", obs, 6'b100100);
    a = 1; b = 0;
    @(posedge clk); #1;
    a = 1; b = 1; #1;
    check("rst_hold_eq", obs, 6'b010010);
    rst = 1;
    @(posedge clk); #1;

    do_reset();
    push_table(16, 16'b1111_1110_1100_0000, 16'b0000_0000_0001_1111, 16'b0000_0001_0010_0000,
               16'h0000, 16'b0000_0000_0001_1111, 16'b1111_1111_1110_0000);
    drive("vec1", 64'b0100_0001_0010_0110, 64'b0100_0110_0100_0110, 16);

    do_reset();
    push_table(16, 16'b1111_1110_1100_0000, 16'b0000_0000_0011_1111, 16'b0000_0001_0000_0000,
               16'b1111_1111_1100_0000, 16'b0000_0000_0011_1111, 16'h0000);
    drive("vec2", 64'b0100_0001_0000_0110, 64'b0101_0110_0100_0110, 16);

    do_reset();
    push_table(16, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
    drive("vec3", 64'b0100_0111_0010_0110, 64'b0100_0111_0010_0110, 16);

    do_reset();
    sb_q.push_back(6'b001001);
    sb_q.push_back(6'b001001);
    drive("vec4", 64'b01, 64'b00, 2);
    a = 0; b = 0;
    @(negedge clk);
    check("vec4_locked", obs, 6'b001001);
    #1 rst = 0;
    #1 check("vec4_async_rst", obs, 6'b010010);
    #1 rst = 1;
    @(posedge clk); #1;
    sb_q.push_back(6'b010010);
    drive("vec4_after", 64'b1, 64'b1, 1);

    for (int t = 0; t < 24; t++) begin
      n = $urandom_range(1, 64);
      va = {$urandom, $urandom};
      vb = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) vb = va ^ (64'd1 << $urandom_range(0, n - 1));
      if (t == 0) vb = va;
      do_reset();
      push_model(va, vb, n);
      drive($sformatf("rnd%0d", t), va, vb, n);
    end

    check("sb_level", 6'(sb_q.size()), 6'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
